// File: rtl/everloop_pkg.sv
// Shared everloop definitions: arbiter state encoding and frame geometry.
// Also used by the everloop sequencing FSM.
package everloop_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_SWAP = 2'd3
    } arb_state_t;

    localparam int DEFAULT_N_LEDS = 35;
    localparam int BYTES_PER_LED  = 4;
    localparam int FRAME_BYTES    = DEFAULT_N_LEDS * BYTES_PER_LED;

endpackage

// File: rtl/everloop_bank_arbiter_if.sv
// Signal bundle between the arbiter, the host write path, the everloop engine and the frame RAM.
interface everloop_bank_arbiter_if #(
    parameter int ADDR_WIDTH = 8
);
    import everloop_pkg::*;

    // Handshakes: host_we/addr/data are held until a one-cycle host_ack (write done or dropped);
    // commit_req and eng_rd_en are single-cycle strobes that are never back-pressured;
    // eng_rd_valid/commit_done are single-cycle pulses; the RAM returns ram_rdata one cycle after ram_addr.
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [7:0]            host_data;
    logic                  host_ack;

    logic                  commit_req;
    logic                  commit_pending;
    logic                  commit_done;
    logic                  front_bank;

    logic                  eng_idle;
    logic                  eng_rd_en;
    logic [ADDR_WIDTH-1:0] eng_rd_addr;
    logic [7:0]            eng_rd_data;
    logic                  eng_rd_valid;

    logic [ADDR_WIDTH:0]   ram_addr;
    logic                  ram_we;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;

    arb_state_t            dbg_state;

    modport slave (
        input  host_we, host_addr, host_data, commit_req, eng_idle, eng_rd_en, eng_rd_addr, ram_rdata,
        output host_ack, commit_pending, commit_done, front_bank, eng_rd_data, eng_rd_valid,
        output ram_addr, ram_we, ram_wdata, dbg_state
    );

    modport master (
        output host_we, host_addr, host_data, commit_req, eng_idle, eng_rd_en, eng_rd_addr, ram_rdata,
        input  host_ack, commit_pending, commit_done, front_bank, eng_rd_data, eng_rd_valid,
        input  ram_addr, ram_we, ram_wdata, dbg_state
    );

endinterface

// File: rtl/everloop_commit_ctrl.sv
// Bank-swap bookkeeping: pending commit flag, displayed bank index and the swap pulse.
module everloop_commit_ctrl (
    input  logic clk,
    input  logic resetn,
    input  logic i_commit_req,
    input  logic i_swap,
    output logic o_commit_pending,
    output logic o_front_bank,
    output logic o_commit_done
);

    logic r_pending;
    logic r_front;
    logic r_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
            r_front   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done  <= i_swap;
            r_front <= r_front ^ i_swap;
            // A request coincident with the swap decision is absorbed by it; one in the swap cycle re-arms.
            if (i_swap) begin
                r_pending <= 1'b0;
            end else if (i_commit_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_commit_pending = r_pending;
    assign o_front_bank     = r_front;
    assign o_commit_done    = r_done;

endmodule

// File: rtl/everloop_bank_arbiter.sv
// Single-port frame RAM arbiter: engine reads the front bank, host writes the back bank,
// banks swap only in the engine's reset gap so a displayed frame never tears.
module everloop_bank_arbiter #(
    parameter int N_LEDS        = everloop_pkg::DEFAULT_N_LEDS,
    parameter int BYTES_PER_LED = everloop_pkg::BYTES_PER_LED,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    everloop_bank_arbiter_if.slave bus
);

    localparam int                  FRAME_BYTES = N_LEDS * BYTES_PER_LED;
    localparam logic [ADDR_WIDTH:0] FRAME_LIMIT = FRAME_BYTES[ADDR_WIDTH:0];

    everloop_pkg::arb_state_t r_state;
    everloop_pkg::arb_state_t w_next;

    logic                  r_host_ack;
    logic                  r_rd_valid;
    logic                  r_ram_we;
    logic [ADDR_WIDTH:0]   r_ram_addr;
    logic [7:0]            r_ram_wdata;

    logic                  w_pending;
    logic                  w_front;
    logic                  w_done;
    logic                  w_swap;
    logic                  w_in_range;

    assign w_in_range = ({1'b0, bus.host_addr} < FRAME_LIMIT);
    assign w_swap     = (w_next == everloop_pkg::S_SWAP);

    // Engine reads never stall; a host write may not directly follow another write.
    always_comb begin
        w_next = everloop_pkg::S_IDLE;
        if (bus.eng_rd_en) begin
            w_next = everloop_pkg::S_RD;
        end else if (w_pending && bus.eng_idle) begin
            w_next = everloop_pkg::S_SWAP;
        end else if (bus.host_we && (r_state != everloop_pkg::S_WR)) begin
            w_next = everloop_pkg::S_WR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= everloop_pkg::S_IDLE;
            r_host_ack  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_state    <= w_next;
            r_host_ack <= 1'b0;
            r_ram_we   <= 1'b0;
            r_rd_valid <= (r_state == everloop_pkg::S_RD);
            // Bank is sampled here, in the grant cycle, from the bank index currently displayed.
            case (w_next)
                everloop_pkg::S_RD: begin
                    r_ram_addr <= {w_front, bus.eng_rd_addr};
                end
                everloop_pkg::S_WR: begin
                    r_host_ack  <= 1'b1;
                    r_ram_we    <= w_in_range;
                    r_ram_addr  <= {~w_front, bus.host_addr};
                    r_ram_wdata <= bus.host_data;
                end
                default: begin
                end
            endcase
        end
    end

    everloop_commit_ctrl u_commit_ctrl (
        .clk              (clk),
        .resetn           (resetn),
        .i_commit_req     (bus.commit_req),
        .i_swap           (w_swap),
        .o_commit_pending (w_pending),
        .o_front_bank     (w_front),
        .o_commit_done    (w_done)
    );

    assign bus.host_ack       = r_host_ack;
    assign bus.commit_pending = w_pending;
    assign bus.commit_done    = w_done;
    assign bus.front_bank     = w_front;
    assign bus.eng_rd_data    = bus.ram_rdata;
    assign bus.eng_rd_valid   = r_rd_valid;
    assign bus.ram_addr       = r_ram_addr;
    assign bus.ram_we         = r_ram_we;
    assign bus.ram_wdata      = r_ram_wdata;
    assign bus.dbg_state      = r_state;

endmodule
